// File: rtl/spi_mem_responder_if.sv
// ---------------------------------------------------------------------------
// spi_mem_responder_if
// CPU request/done memory bus between the cpu core (master) and the SPI
// memory responder (slave).
//   bus_address_in : 16-bit request address        (master -> slave)
//   bus_data_in    : 8-bit write data               (master -> slave)
//   bus_read       : read request level             (master -> slave)
//   bus_write      : write request level            (master -> slave)
//   bus_data_out   : 8-bit read data                (slave -> master)
//   bus_done       : one-cycle completion pulse     (slave -> master)
// ---------------------------------------------------------------------------
interface spi_mem_responder_if;
  logic [15:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        bus_read;
  logic        bus_write;
  logic        bus_done;

  modport master (
    output bus_address_in, bus_data_in, bus_read, bus_write,
    input  bus_data_out, bus_done
  );

  modport slave (
    input  bus_address_in, bus_data_in, bus_read, bus_write,
    output bus_data_out, bus_done
  );
endinterface

// File: rtl/spi_mem_responder.sv
// ---------------------------------------------------------------------------
// spi_mem_responder
// Bus responder that services each CPU read/write request with a single
// 32-bit SPI transaction (opcode, address high, address low, data) to a
// 23LC512-style serial SRAM in SPI mode 0, then pulses bus_done.
// Ports:
//   clk       : system clock, all logic on rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : CPU memory bus (slave modport of spi_mem_responder_if)
//   spi_sclk  : SPI clock, idles low
//   spi_cs_n  : SPI chip select, active low
//   spi_mosi  : SPI serial data to the memory
//   spi_miso  : SPI serial data from the memory
// Parameters:
//   CLK_DIV   : SPI half-period in clk cycles (>= 1)
//   OP_READ   : SPI read opcode
//   OP_WRITE  : SPI write opcode
// ---------------------------------------------------------------------------
module spi_mem_responder #(
  parameter int         CLK_DIV  = 1,
  parameter logic [7:0] OP_READ  = 8'h03,
  parameter logic [7:0] OP_WRITE = 8'h02
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_mem_responder_if.slave        bus,
  output logic                      spi_sclk,
  output logic                      spi_cs_n,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_FINISH  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [1:0]       state_q,    state_d;
  logic [31:0]      shift_q,    shift_d;
  logic [4:0]       bit_cnt_q,  bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
  logic             phase_q,    phase_d;
  logic             sclk_q,     sclk_d;
  logic             cs_n_q,     cs_n_d;
  logic             mosi_q,     mosi_d;
  logic             done_q,     done_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [7:0]       rd_byte_q,  rd_byte_d;
  logic             is_read_q,  is_read_d;

  logic             req;
  logic [31:0]      frame;

  assign req = bus.bus_read | bus.bus_write;

  // Both request lines high counts as a read; a read sends a zero data byte.
  assign frame = bus.bus_read ? {OP_READ, bus.bus_address_in, 8'h00}
                              : {OP_WRITE, bus.bus_address_in, bus.bus_data_in};

  // Next-state logic. phase_q is 0 during the sclk-low half of a bit and 1
  // during the sclk-high half; div_cnt_q times each half. The edge that ends
  // the high half samples MISO, drops sclk and presents the next MOSI bit.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    phase_d    = phase_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    rd_byte_d  = rd_byte_q;
    is_read_d  = is_read_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          is_read_d = bus.bus_read;
          shift_d   = frame;
          mosi_d    = frame[31];
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = 5'd0;
          div_cnt_d = '0;
          phase_d   = 1'b0;
          rd_byte_d = 8'h00;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            // Only the final byte of the frame carries memory read data.
            if (bit_cnt_q >= 5'd24) begin
              rd_byte_d = {rd_byte_q[6:0], spi_miso};
            end
            if (bit_cnt_q == 5'd31) begin
              state_d = ST_FINISH;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              shift_d   = {shift_q[30:0], 1'b0};
              mosi_d    = shift_q[30];
            end
          end
        end
      end

      ST_FINISH: begin
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
        if (is_read_q) begin
          data_out_d = rd_byte_q;
        end
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // Wait for the CPU to drop its request so it is not serviced twice.
        if (!req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 32'h0;
      bit_cnt_q  <= 5'd0;
      div_cnt_q  <= '0;
      phase_q    <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 8'h00;
      rd_byte_q  <= 8'h00;
      is_read_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      rd_byte_q  <= rd_byte_d;
      is_read_q  <= is_read_d;
    end
  end

  assign spi_sclk         = sclk_q;
  assign spi_cs_n         = cs_n_q;
  assign spi_mosi         = mosi_q;
  assign bus.bus_done     = done_q;
  assign bus.bus_data_out = data_out_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_mem_responder
// Drives two responders (CLK_DIV=1 and CLK_DIV=3) with directed CPU
// requests. A behavioural SPI SRAM model per instance records the MOSI
// frame, counts sclk edges and phase lengths, and returns a programmed byte
// on MISO. Expected results are queued when each request is issued and
// popped by a monitor whenever bus_done is seen.
// ---------------------------------------------------------------------------
module tb_spi_mem_responder;

  typedef struct {
    logic [7:0]  dout;
    logic [31:0] mosi;
    logic [31:0] mask;
    int          done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;

  logic [1:0] sclk_w;
  logic [1:0] cs_n_w;
  logic [1:0] mosi_w;
  logic [1:0] miso_w = 2'b00;

  int         n_checks = 0;
  int         n_fail = 0;

  exp_t       sb0[$];
  exp_t       sb1[$];

  // SPI memory model state, one slot per instance
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  done_prev = 2'b00;
  int          rises[2];
  int          hi_run[2];
  int          lo_run[2];
  int          bad_phase[2];
  int          cs_falls[2];
  logic [31:0] mosi_sh[2];
  logic [7:0]  rdata[2];

  spi_mem_responder_if bif0();
  spi_mem_responder_if bif1();

  spi_mem_responder #(.CLK_DIV(1)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif0),
    .spi_sclk (sclk_w[0]),
    .spi_cs_n (cs_n_w[0]),
    .spi_mosi (mosi_w[0]),
    .spi_miso (miso_w[0])
  );

  spi_mem_responder #(.CLK_DIV(3)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif1),
    .spi_sclk (sclk_w[1]),
    .spi_cs_n (cs_n_w[1]),
    .spi_mosi (mosi_w[1]),
    .spi_miso (miso_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int divOf(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI SRAM model: captures MOSI on sclk rise, drives read data on sclk
  // fall for the last byte, and measures every sclk half-period.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !cs_n_w[i]) begin
        cs_falls[i]++;
        rises[i]     = 0;
        mosi_sh[i]   = 32'h0;
        hi_run[i]    = 0;
        lo_run[i]    = 0;
        bad_phase[i] = 0;
        miso_w[i]    = 1'b0;
      end
      if (cs_n_w[i] === 1'b0) begin
        if (!prev_sclk[i] && sclk_w[i]) begin
          mosi_sh[i] = {mosi_sh[i][30:0], mosi_w[i]};
          rises[i]++;
          if (lo_run[i] != divOf(i)) bad_phase[i]++;
          lo_run[i] = 0;
        end else if (prev_sclk[i] && !sclk_w[i]) begin
          if (hi_run[i] != divOf(i)) bad_phase[i]++;
          hi_run[i] = 0;
          if (rises[i] >= 24 && rises[i] < 32) miso_w[i] = rdata[i][31 - rises[i]];
        end
        if (sclk_w[i]) hi_run[i]++;
        else lo_run[i]++;
      end
      prev_cs[i]   = cs_n_w[i];
      prev_sclk[i] = sclk_w[i];
    end
  end

  // Scoreboard monitor: every bus_done pulse is matched against the oldest
  // pending expectation of that instance.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic       done_i;
      logic [7:0] dout_i;
      int         pending;
      exp_t       e;
      done_i  = (i == 0) ? bif0.bus_done : bif1.bus_done;
      dout_i  = (i == 0) ? bif0.bus_data_out : bif1.bus_data_out;
      pending = (i == 0) ? sb0.size() : sb1.size();
      if (done_i === 1'b1) begin
        checkOutput("done_pulse_width", 32'(done_prev[i]), 32'd0);
        if (pending == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: inst %0d got done with no pending request, expected none", i);
        end else begin
          if (i == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          checkOutput("data_out", 32'(dout_i), 32'(e.dout));
          checkOutput("mosi_stream", mosi_sh[i] & e.mask, e.mosi & e.mask);
          checkOutput("sclk_rises", 32'(rises[i]), 32'd32);
          checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
          checkOutput("cs_n_at_done", 32'(cs_n_w[i]), 32'd1);
          checkOutput("phase_errors", 32'(bad_phase[i]), 32'd0);
        end
      end
      done_prev[i] = done_i;
    end
  end

  task automatic applyStimulus(input int inst, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] miso_byte, input logic [7:0] exp_dout,
                               input logic [31:0] exp_mosi, input logic [31:0] mosi_mask,
                               input logic track);
    exp_t e;
    @(negedge clk);
    #1;
    rdata[inst] = miso_byte;
    if (inst == 0) begin
      bif0.bus_address_in = addr;
      bif0.bus_data_in    = wdata;
      bif0.bus_read       = rd;
      bif0.bus_write      = wr;
    end else begin
      bif1.bus_address_in = addr;
      bif1.bus_data_in    = wdata;
      bif1.bus_read       = rd;
      bif1.bus_write      = wr;
    end
    if (track) begin
      e.dout     = exp_dout;
      e.mosi     = exp_mosi;
      e.mask     = mosi_mask;
      e.done_cyc = cyc + 1 + 64 * divOf(inst) + 1;
      if (inst == 0) sb0.push_back(e);
      else           sb1.push_back(e);
    end
  endtask

  task automatic waitDone(input int inst, input int budget);
    int left;
    left = (inst == 0) ? sb0.size() : sb1.size();
    for (int k = 0; k < budget && left != 0; k++) begin
      @(negedge clk);
      #2;
      left = (inst == 0) ? sb0.size() : sb1.size();
    end
    checkOutput("done_timeout", 32'(left), 32'd0);
    if (inst == 0) sb0.delete();
    else           sb1.delete();
  endtask

  task automatic dropRequest(input int inst);
    if (inst == 0) begin
      bif0.bus_read  = 1'b0;
      bif0.bus_write = 1'b0;
    end else begin
      bif1.bus_read  = 1'b0;
      bif1.bus_write = 1'b0;
    end
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; hi_run[i] = 0; lo_run[i] = 0; bad_phase[i] = 0;
      cs_falls[i] = 0; mosi_sh[i] = 32'h0; rdata[i] = 8'h00;
    end
    bif0.bus_address_in = 16'h0; bif0.bus_data_in = 8'h0;
    bif0.bus_read = 1'b0;        bif0.bus_write = 1'b0;
    bif1.bus_address_in = 16'h0; bif1.bus_data_in = 8'h0;
    bif1.bus_read = 1'b0;        bif1.bus_write = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_cs_n_0", 32'(cs_n_w[0]), 32'd1);
    checkOutput("reset_sclk_0", 32'(sclk_w[0]), 32'd0);
    checkOutput("reset_mosi_0", 32'(mosi_w[0]), 32'd0);
    checkOutput("reset_done_0", 32'(bif0.bus_done), 32'd0);
    checkOutput("reset_dout_0", 32'(bif0.bus_data_out), 32'h00);
    checkOutput("reset_cs_n_1", 32'(cs_n_w[1]), 32'd1);
    checkOutput("reset_dout_1", 32'(bif1.bus_data_out), 32'h00);
    rst_n = 1'b1;

    $display("[TB] read 0x1234 returning 0xA5");
    applyStimulus(0, 1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, 8'hA5, 32'h0312_3400, 32'hFFFF_FF00, 1'b1);
    waitDone(0, 100);
    dropRequest(0);

    $display("[TB] write 0x5A to 0xBEEF");
    applyStimulus(0, 1'b0, 1'b1, 16'hBEEF, 8'h5A, 8'hFF, 8'hA5, 32'h02BE_EF5A, 32'hFFFF_FFFF, 1'b1);
    waitDone(0, 100);
    dropRequest(0);

    $display("[TB] held request is not re-serviced");
    applyStimulus(0, 1'b1, 1'b0, 16'h0F0F, 8'h00, 8'h81, 8'h81, 32'h030F_0F00, 32'hFFFF_FF00, 1'b1);
    waitDone(0, 100);
    snap = cs_falls[0];
    repeat (10) @(negedge clk);
    checkOutput("no_reservice", 32'(cs_falls[0]), 32'(snap));
    dropRequest(0);
    applyStimulus(0, 1'b1, 1'b0, 16'h1111, 8'h00, 8'h42, 8'h42, 32'h0311_1100, 32'hFFFF_FF00, 1'b1);
    waitDone(0, 100);
    checkOutput("new_txn_after_drop", 32'(cs_falls[0]), 32'(snap + 1));
    dropRequest(0);

    $display("[TB] read and write both high");
    applyStimulus(0, 1'b1, 1'b1, 16'h0001, 8'hFF, 8'h99, 8'h99, 32'h0300_0100, 32'hFFFF_FFFF, 1'b1);
    waitDone(0, 100);
    dropRequest(0);

    $display("[TB] reset during a write");
    applyStimulus(0, 1'b0, 1'b1, 16'h2222, 8'h33, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 100 && rises[0] < 12; k++) @(negedge clk);
    checkOutput("reached_bit12", 32'(rises[0] >= 12), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", 32'(cs_n_w[0]), 32'd1);
    checkOutput("abort_sclk", 32'(sclk_w[0]), 32'd0);
    checkOutput("abort_dout", 32'(bif0.bus_data_out), 32'h00);
    checkOutput("abort_done", 32'(bif0.bus_done), 32'd0);
    dropRequest(0);
    snap = cs_falls[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("idle_after_abort", 32'(cs_falls[0]), 32'(snap));
    applyStimulus(0, 1'b1, 1'b0, 16'h0002, 8'h00, 8'h77, 8'h77, 32'h0300_0200, 32'hFFFF_FF00, 1'b1);
    waitDone(0, 100);
    dropRequest(0);

    $display("[TB] CLK_DIV=3 read 0x00FF returning 0x3C");
    applyStimulus(1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 8'h3C, 32'h0300_FF00, 32'hFFFF_FF00, 1'b1);
    waitDone(1, 300);
    dropRequest(1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- Bus responder (target) for the CPU's request/done memory bus.
- Services each bus_read / bus_write request with one serial transaction to an external SPI SRAM: 23LC512-style, mode 0, 16-bit address.
- Pulses bus_done when the transaction is complete.
- Sits between the cpu core and the chip's SPI memory pins; it is the only responder on the bus.

Parameters:
- CLK_DIV, 1: SPI half-period in clk cycles (>=1). One SPI bit takes 2*CLK_DIV clk cycles.
- OP_READ, 8'h03: SPI read opcode.
- OP_WRITE, 8'h02: SPI write opcode.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- bus_address_in  input  16  request address from CPU
- bus_data_in  input  8  write data from CPU
- bus_data_out  output  8  read data to CPU
- bus_read  input  1  read request level
- bus_write  input  1  write request level
- bus_done  output  1  one-cycle completion pulse
- spi_sclk  output  1  SPI clock, idles low
- spi_cs_n  output  1  SPI chip select, active low
- spi_mosi  output  1  SPI data out
- spi_miso  input  1  SPI data in

Behaviour:

Reset:
- rst_n low forces, asynchronously and independent of clk: state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, bus_done=0, bus_data_out=8'h00, all counters and shift registers cleared.
- Reset asserted mid-transaction aborts the transaction immediately. No bus_done is produced.
- The first request after reset release is handled normally.

States: IDLE, SHIFT, FINISH, RELEASE.

IDLE:
- On a clk edge with (bus_read | bus_write) high, capture:
  - address
  - write data
  - op = read if bus_read is high, else write. Both high is treated as a read.
- Load the 32-bit shift register = {opcode, address[15:8], address[7:0], wdata}. For a read, the wdata byte is 8'h00.
- At the same edge: spi_cs_n<=0, spi_mosi<=bit31, bit counter=0, phase=low. Next state SHIFT.

SHIFT (32 bits, MSB first, SPI mode 0):
- Each bit has a low phase of CLK_DIV cycles (sclk=0, mosi stable) and a high phase of CLK_DIV cycles (sclk=1).
- spi_miso is sampled on the clk edge that ends the high phase.
- At that same edge: sclk<=0 and mosi<=next bit.
- Only bits 24..31 (the data byte) are shifted into the read-data register.
- After the high phase of bit 31 ends: sclk=0, next state FINISH.

FINISH (1 cycle):
- spi_cs_n<=1 and bus_done<=1.
- For a read, bus_data_out<=captured byte; for a write, bus_data_out is unchanged.
- Next state RELEASE.

RELEASE:
- bus_done<=0.
- Stay until bus_read and bus_write are both low, then go to IDLE.
- This prevents a still-held request (the CPU drops it the cycle after it samples done) from being re-serviced.

Latency and timing:
- With acceptance edge E0, bus_done is high for exactly the one cycle following edge E0+64*CLK_DIV+1.
- Minimum spi_cs_n high time between transactions: 2 cycles (FINISH→RELEASE→IDLE with request low).

Input changes during a transaction:
- Changes on bus_address_in or bus_data_in after acceptance are ignored; captured values are used.
- A request that drops before done is still completed and still produces bus_done.

Output rules:
- bus_done is never high for more than 1 cycle.
- bus_done is never high while spi_cs_n=0.
- spi_sclk toggles only while spi_cs_n=0.

Test Plan:
- Read 0x1234, SPI model returns 0xA5 → MOSI stream 0x03,0x12,0x34 then 8 don't-care bits. bus_data_out=0xA5 when bus_done=1. Done follows edge E0+65 (CLK_DIV=1). Exactly 32 sclk rising edges.
- Write addr 0xBEEF, data 0x5A → MOSI stream 0x02,0xBE,0xEF,0x5A. bus_data_out keeps its previous value (0xA5). Single done pulse.
- Hold bus_read high for 10 cycles after done → no new cs_n falling edge. Drop bus_read, then raise it again → a new transaction starts.
- bus_read and bus_write both high, addr 0x0001 → read opcode 0x03 issued, write data not driven on MOSI.
- Assert rst_n low at bit 12 of a write → spi_cs_n=1 and spi_sclk=0 immediately (before the next clk edge), no done, bus_data_out=0x00. After release, a read of 0x0002 completes correctly.
- CLK_DIV=3, read 0x00FF returning 0x3C → sclk high and low phases are each 3 cycles, done after edge E0+193, bus_data_out=0x3C.
